wormhole_arbiter: RTL

WORMHOLE_ARBITER -- requirements
Module: wormhole_arbiter

---
 rtl/wormhole_arbiter_pkg.sv | 27 ++
 rtl/wormhole_arbiter_rr_priority_select.sv | 29 ++
 rtl/wormhole_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/wormhole_arbiter_pkg.sv
// Shared NoC definitions for the output-port arbiter blocks.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package wormhole_arbiter_pkg;

    // Number of input ports competing for one output port.
    localparam int NOC_NUM_PORTS = 4;

    // Output-port ownership FSM.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Binary index of a one-hot vector; zero for an all-zero vector.
    function automatic logic [1:0] onehot_to_idx(input logic [NOC_NUM_PORTS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NOC_NUM_PORTS; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wormhole_arbiter_rr_priority_select.sv
// Rotating-priority pick: first set bit of eligible searching upward from rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 and grant_oh=0 when nothing is eligible.
// Ports: eligible (4b request vector), rr_ptr (2b start index), grant_oh (4b one-hot), found.
module rr_priority_select
    import wormhole_arbiter_pkg::*;
(
    input  logic [NOC_NUM_PORTS-1:0] eligible,
    input  logic [1:0]               rr_ptr,
    output logic [NOC_NUM_PORTS-1:0] grant_oh,
    output logic                     found
);

    always_comb begin
        logic [1:0] idx;
        idx      = 2'd0;
        grant_oh = '0;
        found    = 1'b0;
        for (int k = 0; k < NOC_NUM_PORTS; k++) begin
            // 2-bit add wraps 3 -> 0 naturally.
            idx = rr_ptr + 2'(k);
            if (!found && eligible[idx]) begin
                grant_oh[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wormhole_arbiter.sv
// Wormhole output-port arbiter: locks the port to one input from header to tail transfer.
// Latency: one cycle from eligible header to registered grant; out_valid is combinational once locked.
// Backpressure: out_ready=0 holds the granted input (port_block[g]=1); a stalled tail keeps the lock.
// Ports: clk, reset (sync, active-high); req_valid/req_head/req_tail (per input), req_addr (2b per input);
//        out_ready; grant (one-hot), mux_select, port_block, out_valid, busy.
module wormhole_arbiter
    import wormhole_arbiter_pkg::*;
#(
    parameter logic [1:0] PORT_ADDR = 2'd0,
    parameter int         NUM_IN    = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IN-1:0]     req_valid,
    input  logic [NUM_IN-1:0]     req_head,
    input  logic [NUM_IN-1:0]     req_tail,
    input  logic [2*NUM_IN-1:0]   req_addr,
    input  logic                  out_ready,
    output logic [NUM_IN-1:0]     grant,
    output logic [1:0]            mux_select,
    output logic [NUM_IN-1:0]     port_block,
    output logic                  out_valid,
    output logic                  busy
);

    arb_state_t        state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [1:0]        mux_q, mux_d;
    logic [1:0]        rr_ptr, rr_ptr_d;
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] sel_oh;
    logic              sel_found;

    // Only headers addressed to this output port may open a new packet.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = req_valid[i] & req_head[i] & (req_addr[2*i +: 2] == PORT_ADDR);
        end
    end

    rr_priority_select u_sel (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant_oh (sel_oh),
        .found    (sel_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            mux_q   <= 2'd0;
            rr_ptr  <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mux_q   <= mux_d;
            rr_ptr  <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mux_d     = mux_q;
        rr_ptr_d  = rr_ptr;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // mux_select keeps its last value while idle; only grant is cleared.
                grant_d = '0;
                if (sel_found) begin
                    state_d = LOCKED;
                    grant_d = sel_oh;
                    mux_d   = onehot_to_idx(sel_oh);
                end
            end
            LOCKED: begin
                out_valid = req_valid[mux_q];
                // Release only when the tail actually transfers; priority moves past the winner.
                if (out_valid && out_ready && req_tail[mux_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = mux_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant      = grant_q;
    assign mux_select = mux_q;
    assign busy       = (state_q == LOCKED);
    // grant_q is zero in IDLE, so every input is blocked there; the owner is blocked only by downstream.
    assign port_block = ~grant_q | {NUM_IN{~out_ready}};

endmodule
